// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// One line bit per CLK cycle. TX_OUT and busy come straight from flops, so the
// line cannot glitch. They follow the FSM state one edge later.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    par_en_reg;
    logic                    par_bit_reg;
    logic                    armed_reg;
    logic                    tx_reg, tx_next;
    logic                    busy_reg, busy_next;
    logic                    accept;

    // armed_reg blocks an accept on the first edge after reset release.
    assign accept = (state_reg == IDLE) && DATA_VALID && armed_reg;

    // State register and bit counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // Next-state logic; the counter only advances while shifting data
    always_comb begin
        state_next   = IDLE;
        bit_cnt_next = '0;
        case (state_reg)
            IDLE:   state_next = accept ? START : IDLE;
            START:  state_next = DATA;
            DATA: begin
                if (bit_cnt_reg == LAST_BIT) begin
                    bit_cnt_next = '0;
                    state_next   = par_en_reg ? PARITY : STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    state_next   = DATA;
                end
            end
            PARITY: state_next = STOP;
            STOP:   state_next = IDLE;
            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Shadow copy of the request, captured only on accept.
    // The parity bit is also precomputed here.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
        end else if (accept) begin
            data_reg    <= P_DATA;
            par_en_reg  <= PAR_EN;
            par_bit_reg <= PAR_TYP ? ~^P_DATA : ^P_DATA;
        end
    end

    // Arms the accept path once RST has been high for one edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
        end
    end

    // Output mux: line level and busy flag for the current state
    always_comb begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
            START: begin
                tx_next   = 1'b0;
                busy_next = 1'b1;
            end
            DATA: begin
                tx_next   = data_reg[bit_cnt_reg];
                busy_next = 1'b1;
            end
            PARITY: begin
                tx_next   = par_bit_reg;
                busy_next = 1'b1;
            end
            STOP: begin
                tx_next   = 1'b1;
                busy_next = 1'b1;
            end
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

    // Registered outputs; reset drives the line high without a clock
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
        end else begin
            tx_reg   <= tx_next;
            busy_reg <= busy_next;
        end
    end

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. A frame-level model (a queue of expected line bits) is
// compared every cycle. Directed frames are also pinned against hand-written
// line sequences and a decoder of the captured line.
module tb_uart_tx;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    // Frame-level model. An accepted request pushes the whole frame's line
    // bits; each later edge emits one of them. Requests are honoured only when
    // nothing is pending and RST has been high for an edge.
    logic m_q[$];
    logic m_tx    = 1'b1;
    logic m_busy  = 1'b0;
    logic m_armed = 1'b0;

    initial forever begin
        @(posedge CLK or negedge RST);
        if (!RST) begin
            m_q.delete();
            m_tx    = 1'b1;
            m_busy  = 1'b0;
            m_armed = 1'b0;
        end else if (m_q.size() > 0) begin
            m_tx    = m_q.pop_front();
            m_busy  = 1'b1;
            m_armed = 1'b1;
        end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
            if (m_armed && DATA_VALID) begin
                m_q.push_back(1'b0);
                for (int i = 0; i < DW; i++) m_q.push_back(P_DATA[i]);
                if (PAR_EN) m_q.push_back((($countones(P_DATA) % 2) == 1) ^ PAR_TYP);
                m_q.push_back(1'b1);
            end
            m_armed = 1'b1;
        end
    end

    // Per-cycle compare against the model
    logic cmp_en = 1'b0;
    initial forever begin
        @(negedge CLK);
        if (cmp_en) begin
            checks++;
            if (TX_OUT !== m_tx || busy !== m_busy) begin
                errors++;
                $display("FAIL model_cmp t=%0t tx=%b busy=%b expected tx=%b busy=%b",
                         $time, TX_OUT, busy, m_tx, m_busy);
            end
        end
    end

    // Line history, sampled 1 time unit after each rising edge
    logic hist_tx   [0:1023];
    logic hist_busy [0:1023];
    int   cyc = 0;
    initial forever begin
        @(posedge CLK);
        #1;
        if (cyc < 1024) begin
            hist_tx[cyc]   = TX_OUT;
            hist_busy[cyc] = busy;
        end
        cyc++;
    end

    task automatic check_seq(input string name, input int t0, input logic [31:0] exp,
                             input int len, input int exp_busy);
        logic [31:0] got;
        int nb;
        got = '0;
        nb  = 0;
        for (int i = 0; i < len; i++) begin
            got[len-1-i] = hist_tx[t0+i];
            nb += int'(hist_busy[t0+i]);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s line got=%b expected=%b", name, got, exp);
        end
        checks++;
        if (nb != exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d expected=%0d", name, nb, exp_busy);
        end
    endtask

    // Decode a captured frame and compare it with the request and the parity rule
    task automatic check_decode(input string name, input int t0, input logic [DW-1:0] d,
                                input logic pt);
        logic [DW-1:0] got_d;
        logic exp_p;
        for (int i = 0; i < DW; i++) got_d[i] = hist_tx[t0+2+i];
        exp_p = (($countones(d) % 2) == 1) ^ pt;
        checks++;
        if (got_d !== d) begin
            errors++;
            $display("FAIL %s decoded_data got=%h expected=%h", name, got_d, d);
        end
        checks++;
        if (hist_tx[t0+2+DW] !== exp_p) begin
            errors++;
            $display("FAIL %s decoded_parity got=%b expected=%b", name, hist_tx[t0+2+DW], exp_p);
        end
    endtask

    task automatic check_now(input string name, input logic exp_tx, input logic exp_busy);
        checks++;
        if (TX_OUT !== exp_tx || busy !== exp_busy) begin
            errors++;
            $display("FAIL %s tx=%b busy=%b expected tx=%b busy=%b",
                     name, TX_OUT, busy, exp_tx, exp_busy);
        end
    endtask

    // Called just after a falling edge; one-cycle DATA_VALID pulse
    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, output int t0);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        t0         = cyc;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        $display("sent data=%h par_en=%b par_typ=%b at sample %0d", d, pe, pt, t0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    int t0;

    initial begin
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        idle(3);
        check_now("reset_state", 1'b1, 1'b0);
        cmp_en = 1'b1;
        RST    = 1'b1;
        idle(2);

        // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
        send(8'hA5, 1'b1, 1'b0, t0);
        idle(16);
        check_seq("a5_even", t0, 32'b1010100101011111, 16, 11);

        // 0xA5 odd parity: parity bit 1
        send(8'hA5, 1'b1, 1'b1, t0);
        idle(16);
        check_seq("a5_odd", t0, 32'b1010100101111111, 16, 11);

        // 0x3C no parity: 0,0,0,1,1,1,1,0,0,1
        send(8'h3C, 1'b0, 1'b0, t0);
        idle(16);
        check_seq("3c_nopar", t0, 32'b1000111100111111, 16, 10);

        // Mid-frame request with new data must be dropped
        send(8'hA5, 1'b1, 1'b0, t0);
        idle(3);
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        idle(14);
        check_seq("a5_ignore_req", t0, 32'b1010100101011111, 16, 11);

        // DATA_VALID held across two frames: 0x01 then 0x80, one idle cycle between
        P_DATA     = 8'h01;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        t0         = cyc;
        @(negedge CLK);
        P_DATA = 8'h80;
        idle(11);
        DATA_VALID = 1'b0;
        idle(16);
        check_seq("b2b_01_80", t0, 32'b101000000011000000001111, 24, 20);

        // 0xFF odd parity -> parity 1
        send(8'hFF, 1'b1, 1'b1, t0);
        idle(16);
        check_seq("ff_odd", t0, 32'b1011111111111111, 16, 11);
        check_decode("ff_odd", t0, 8'hFF, 1'b1);

        // 0x00 even parity -> parity 0
        send(8'h00, 1'b1, 1'b0, t0);
        idle(16);
        check_seq("00_even", t0, 32'b1000000000011111, 16, 11);
        check_decode("00_even", t0, 8'h00, 1'b0);

        // Reset during data bit 3 of 0x00: line high immediately, no clock needed
        send(8'h00, 1'b0, 1'b0, t0);
        idle(5);
        check_now("bit3_before_reset", 1'b0, 1'b1);
        #2 RST = 1'b0;
        #1;
        check_now("async_reset", 1'b1, 1'b0);
        idle(2);
        RST = 1'b1;
        t0  = cyc;
        idle(16);
        check_seq("idle_after_reset", t0, 32'b1111111111111111, 16, 0);

        // DATA_VALID high at reset release: first edge ignored, accept on the second
        #2 RST = 1'b0;
        @(negedge CLK);
        RST        = 1'b1;
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        t0         = cyc;
        idle(2);
        DATA_VALID = 1'b0;
        idle(16);
        check_seq("valid_at_release", t0, 32'b1100011110011111, 16, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: the transmit end of the same serial protocol our RX chain decodes (start bit, LSB-first data, optional parity, one stop bit). It accepts a parallel word with a valid strobe, serializes it at one bit per `CLK` cycle, and drives the line with a registered, glitch-free output. `CLK` is the TX bit clock: the RX side's oversampling clock divided by `prescale`, generated outside this block. The block is built from an FSM, a serializer with bit counter, a parity calculator and an output mux.

## Interface
- `DATA_WIDTH`, default 8: frame data bits; the bit counter is sized `$clog2(DATA_WIDTH)`.
- `CLK`  in  1: TX bit clock; all state updates on the rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH: word to transmit; sampled only on accept.
- `DATA_VALID`  in  1: request to send `P_DATA`; honoured only when `busy`=0.
- `PAR_EN`  in  1: 1 = insert a parity bit; sampled on accept.
- `PAR_TYP`  in  1: 0 = even, 1 = odd; sampled on accept.
- `TX_OUT`  out  1: serial line, idle high, registered.
- `busy`  out  1: frame in progress, registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: state IDLE and `DATA_VALID`=1 at a rising edge.
- On accept, register `P_DATA`, `PAR_EN` and `PAR_TYP` into shadow registers. Later input changes never affect the frame.
- On accept, compute and register the parity bit: even gives `^data`, odd gives `~^data`.
- IDLE: `TX_OUT`=1, `busy`=0. Goes to START on accept; otherwise stays in IDLE.
- START: `TX_OUT`=0 for 1 cycle, then DATA.
- DATA: `TX_OUT`=data[bit_cnt], starting at bit_cnt=0 (LSB first). The counter increments each cycle.
  - At bit_cnt=DATA_WIDTH-1, clear the counter and go to PARITY if latched `PAR_EN`=1, else to STOP.
- PARITY: `TX_OUT`=latched parity bit for 1 cycle, then STOP.
- STOP: `TX_OUT`=1 for 1 cycle, then IDLE.
- `busy`=1 in START, DATA, PARITY and STOP; 0 only in IDLE.
- `DATA_VALID` while `busy`=1 is ignored: no queueing and no error flag. The upstream block must hold or re-issue the request.
- Unreachable state encodings recover to IDLE on the next edge, with `TX_OUT`=1 and `busy`=0.

## Timing
- Reset values (asynchronous, on `RST` low): state IDLE, `TX_OUT`=1, `busy`=0, bit counter 0, shadow registers 0.
- Reset asserted mid-frame aborts the frame immediately. `TX_OUT` returns high without waiting for a clock, and no partial bits follow after reset release.
- Accept at edge k. The start bit appears on `TX_OUT` after edge k+1, and `busy` rises after that same edge.
- Data bit i is driven after edge k+2+i.
- With DATA_WIDTH=8, the parity bit (if enabled) is driven after edge k+10.
- The stop bit is driven after edge k+10 (no parity) or k+11 (parity).
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- `busy` falls one cycle after the stop bit is first driven, when the FSM enters IDLE.
- Back-to-back frames: a new accept is possible on the first IDLE edge. This gives a minimum of 1 idle-high cycle between frames, so the frame period is 11 or 12 cycles at DATA_WIDTH=8.
- `DATA_VALID` arriving in the same cycle as reset release is ignored until `RST` has been high for one edge.

## Test plan
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, 1-cycle `DATA_VALID` pulse -> `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0), then idle 1. `busy` is high for exactly 11 cycles.
- Same word with `PAR_TYP`=1 -> parity bit 1. With `PAR_EN`=0, `P_DATA`=0x3C -> 0,0,0,1,1,1,1,0,0,1, and `busy` is high for 10 cycles.
- During a frame, change `P_DATA` to 0xFF and pulse `DATA_VALID` -> the current frame is unaltered, the second request is dropped, and `TX_OUT` stays 1 after STOP.
- Hold `DATA_VALID`=1 with 0x01, then 0x80, across two frames -> two complete frames separated by exactly one idle-high cycle, at a 11-cycle period with `PAR_EN`=0.
- Assert `RST` low during data bit 3 of 0x00 -> `TX_OUT`=1 and `busy`=0 immediately, with no clock edge. After release, the line stays idle until a new `DATA_VALID`.
- `P_DATA`=0xFF, odd parity -> parity bit 1. `P_DATA`=0x00, even parity -> parity bit 0. Both checked against a scoreboard model that decodes `TX_OUT`.
